// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, bus response codes and the reset/NOP constants.
package ifu_fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_e;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch stage's memory read channel, decode handshake and redirect port.
// master = the fetch unit, slave = memory plus decode/execute as seen from outside.
interface ifu_fetch_if
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_err;

  modport master (
    output araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
    input  arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
    output arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// Architectural PC with redirect priority: a redirect that arrives while a request
// is still waiting for arready is parked in pending_pc so araddr stays stable.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_req,
  input  logic            accept,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            pend
);

  logic [XLEN-1:0] pending_pc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pending_pc <= '0;
      pend       <= 1'b0;
    end else if (redirect) begin
      if (in_req && !accept) begin
        pending_pc <= redirect_pc;
        pend       <= 1'b1;
      end else begin
        pc   <= redirect_pc;
        pend <= 1'b0;
      end
    end else if (accept && pend) begin
      pc   <= pending_pc;
      pend <= 1'b0;
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: single-outstanding AR/R reads at pc, one held instruction
// toward decode, redirects from execute, sticky halt on bus error or misaligned target.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic [XLEN-1:0] pc;
  logic            pend;
  logic            stale;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            redirect_ok;
  logic            misaligned;
  logic            accept;
  logic            advance;

  assign redirect_ok = bus.redirect_valid && is_aligned(bus.redirect_pc[1:0]) && (state != HALT);
  assign misaligned  = bus.redirect_valid && !is_aligned(bus.redirect_pc[1:0]) && (state != HALT);
  assign accept      = (state == REQ) && bus.arready;
  assign advance     = (state == HOLD) && bus.inst_ready;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .in_req      (state == REQ),
    .accept      (accept),
    .advance     (advance),
    .redirect    (redirect_ok),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc),
    .pend        (pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    next_state = state;
    if (misaligned) begin
      next_state = HALT;
    end else begin
      case (state)
        IDLE: next_state = REQ;
        REQ:  if (bus.arready) next_state = WAIT;
        WAIT: begin
          if (bus.rvalid) begin
            if (redirect_ok || stale)         next_state = REQ;
            else if (bus.rresp != RESP_OKAY)  next_state = HALT;
            else                              next_state = HOLD;
          end
        end
        HOLD:    if (redirect_ok || bus.inst_ready) next_state = REQ;
        HALT:    next_state = HALT;
        default: next_state = HALT;
      endcase
    end
  end

  // A response whose request was overtaken by a redirect is marked stale and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale     <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else if (next_state == HALT) begin
      stale     <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      if (accept) begin
        stale <= redirect_ok || pend;
      end else if (state == WAIT) begin
        if (bus.rvalid)       stale <= 1'b0;
        else if (redirect_ok) stale <= 1'b1;
      end
      if (state == WAIT && next_state == HOLD) begin
        inst_q    <= bus.rdata;
        inst_pc_q <= pc;
      end
    end
  end

  always_comb begin
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.inst_valid = 1'b0;
    bus.fetch_err  = 1'b0;
    bus.araddr     = (state == HALT) ? '0 : pc;
    bus.inst       = inst_q;
    bus.inst_pc    = inst_pc_q;
    case (state)
      REQ:     bus.arvalid    = 1'b1;
      WAIT:    bus.rready     = 1'b1;
      HOLD:    bus.inst_valid = 1'b1;
      HALT:    bus.fetch_err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the execute stage (ALU, branch-condition, data-memory logic).
- Owns the architectural PC and issues single-outstanding read requests on a valid/ready bus (AR/R style) to instruction memory.
- Presents each fetched instruction with its PC to the decode/execute path through a valid/ready handshake.
- Accepts PC redirects computed by the execute stage for taken branches, jal and jalr.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- XLEN, 32, width of PC, addresses and instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- araddr  out  XLEN  fetch address, equal to the current PC.
- arvalid  out  1  read request valid.
- arready  in  1  memory accepts the request.
- rdata  in  32  instruction word returned by memory.
- rresp  in  2  2'b00 = OKAY; any other value is a bus error.
- rvalid  in  1  read data valid.
- rready  out  1  fetch stage accepts read data.
- inst  out  32  fetched instruction.
- inst_pc  out  XLEN  PC of `inst`.
- inst_valid  out  1  `inst` and `inst_pc` are valid.
- inst_ready  in  1  downstream consumes the instruction.
- redirect_valid  in  1  one-cycle pulse: the next PC is non-sequential.
- redirect_pc  in  XLEN  target PC (branch, jal or jalr result).
- fetch_err  out  1  sticky fault flag; fetch halts while it is set.

Behaviour:
- Reset values, held while rst=1:
  - state=IDLE, pc=RESET_PC.
  - arvalid=0, rready=0, inst_valid=0, fetch_err=0.
  - inst=0, inst_pc=0, stale=0.
- FSM states and transitions:
  - IDLE: move to REQ on the first clk edge after rst deasserts.
  - REQ: arvalid=1, araddr=pc. On arvalid&&arready, go to WAIT.
  - WAIT: rready=1. On rvalid:
    - rresp!=0 and not stale: set fetch_err, go to HALT.
    - stale: discard rdata, clear stale, go to REQ (pc already holds the redirect target).
    - otherwise: register inst=rdata and inst_pc=pc, set inst_valid, go to HOLD.
  - HOLD: inst_valid=1, with inst and inst_pc stable. On inst_ready: pc<=pc+4 (wraps modulo 2^XLEN), inst_valid<=0, go to REQ.
  - HALT: all outputs low except fetch_err. Only rst exits.
- Latency: a zero-wait memory (arready=1, rvalid one cycle after acceptance) gives REQ→WAIT→HOLD = 3 cycles per instruction. Throughput is 1 instruction per ≥3 cycles; no prefetch.
- Handshake rules:
  - Once arvalid is high, araddr and arvalid stay stable until arready.
  - inst, inst_pc and inst_valid stay stable until inst_ready or a redirect.
  - rready is high only in WAIT.
- Redirect handling (redirect_valid sampled at posedge):
  - IDLE: pc<=redirect_pc; the first fetch uses the target.
  - REQ without arready: pc is not changed (address stability). The target is latched into pending_pc with pend=1. On acceptance, go to WAIT with stale=1 and pc<=pending_pc.
  - REQ with arready in the same cycle: pc<=redirect_pc, stale=1.
  - WAIT: pc<=redirect_pc, stale=1; the in-flight response is dropped.
  - HOLD: held instruction discarded, inst_valid<=0, pc<=redirect_pc, go to REQ. Redirect wins over a simultaneous inst_ready.
  - HALT: ignored.
- Alignment: redirect_pc[1:0]!=0 sets fetch_err and moves to HALT immediately. Any in-flight response is ignored.
- A bus error on a stale response is ignored and does not set fetch_err.
- Asynchronous reset mid-transaction: all state clears immediately and the outstanding bus response is not tracked. The memory model must tolerate a dropped rready.

Decomposition:
- Shared package: fetch FSM state enum (IDLE, REQ, WAIT, HOLD, HALT), RESP_OKAY=2'b00, RESET_PC default, INST_NOP=32'h0000_0013.
- One sub-module, ifu_pc_reg:
  - Holds pc, pending_pc and pend.
  - Inputs: advance (pc+4), redirect, accept.
  - Keeps the redirect priority logic separate from the bus FSM.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0013 → araddr=32'h8000_0000 in cycle 1; inst_valid=1 with inst_pc=32'h8000_0000 in cycle 3; next araddr=32'h8000_0004.
- Downstream inst_ready held low 5 cycles → inst and inst_pc unchanged, arvalid=0 throughout; one cycle after inst_ready=1, araddr=32'h8000_0004.
- Memory delays arready 3 cycles; redirect_pc=32'h8000_0100 pulses during the second cycle:
  - araddr stays 32'h8000_0000 until accepted.
  - The response is dropped.
  - The next request is 32'h8000_0100; the first inst_pc delivered is 32'h8000_0100.
- Redirect to 32'h8000_0040 asserted together with inst_ready in HOLD → held instruction not re-presented; next araddr=32'h8000_0040, not 32'h8000_0004.
- rresp=2'b10 on a non-stale response → fetch_err=1 next cycle, arvalid and inst_valid stay 0 until rst; redirect_pc=32'h8000_0102 from a fresh reset also sets fetch_err.
- Assert rst asynchronously in WAIT mid-transaction → outputs reach reset values before the next clk edge; fetch restarts at 32'h8000_0000.
